// File: rtl/seg_pkg.sv
// Shared constants for the segment display sequencer: FSM encoding, the blank
// digit code and the default blink timing for a 25 MHz system clock.
package seg_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_FLASH_ON  = 2'd1;
    localparam logic [1:0] ST_FLASH_OFF = 2'd2;

    // 4'hF falls through to the decoder's default (all segments off) path.
    localparam logic [3:0] BLANK_DIGIT = 4'hF;

    // 0.5 s per blink phase at 25 MHz.
    localparam int DEFAULT_HALF_PERIOD = 12500000;

endpackage

// File: rtl/phase_timer.sv
// Phase cycle counter: counts 0..HALF_PERIOD-1 while enabled, pulses o_Tc on the
// last count and restarts from zero. Reusable for blink and debounce timing.
module phase_timer #(
    parameter int HALF_PERIOD = 4
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Clr,
    input  logic i_En,
    output logic o_Tc
);

    localparam int TW = $clog2(HALF_PERIOD);
    localparam logic [TW-1:0] TC_VAL = TW'(HALF_PERIOD - 1);

    logic [TW-1:0] count;

    assign o_Tc = i_En && (count == TC_VAL);

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            count <= '0;
        end else if (i_Clr || o_Tc) begin
            count <= '0;
        end else if (i_En) begin
            count <= count + TW'(1);
        end
    end

endmodule

// File: rtl/segment_display_sequencer.sv
// Owns the 7-segment decoder's digit input: shows the level, or blinks a latched
// flash value a requested number of times, with blanking and a done pulse.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | showing i_Level, accepting flash requests
// ST_FLASH_ON  | blink on phase, showing the latched flash value
// ST_FLASH_OFF | blink off phase, blank; last terminal count ends the sequence
module segment_display_sequencer
    import seg_pkg::*;
#(
    parameter int HALF_PERIOD = DEFAULT_HALF_PERIOD,
    parameter int CNT_W       = 3
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    input  logic [3:0]       i_Level,
    input  logic             i_Flash_Req,
    input  logic [3:0]       i_Flash_Value,
    input  logic [CNT_W-1:0] i_Flash_Count,
    input  logic             i_Blank,
    output logic [3:0]       o_Digit,
    output logic             o_Busy,
    output logic             o_Flash_Done
);

    logic [1:0]       state;
    logic [3:0]       flash_value;
    logic [CNT_W-1:0] remaining;
    logic             accept;
    logic             timer_en;
    logic             timer_tc;

    // A request landing on the done cycle is dropped; requesters wait for !o_Busy.
    assign accept   = (state == ST_IDLE) && i_Flash_Req && (i_Flash_Count != '0) && !o_Flash_Done;
    assign timer_en = (state != ST_IDLE);

    phase_timer #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_phase_timer (
        .i_Clk  (i_Clk),
        .i_Rst_L(i_Rst_L),
        .i_Clr  (accept),
        .i_En   (timer_en),
        .o_Tc   (timer_tc)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state        <= ST_IDLE;
            flash_value  <= '0;
            remaining    <= '0;
            o_Busy       <= 1'b0;
            o_Flash_Done <= 1'b0;
        end else begin
            o_Flash_Done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state       <= ST_FLASH_ON;
                        flash_value <= i_Flash_Value;
                        remaining   <= i_Flash_Count;
                        o_Busy      <= 1'b1;
                    end
                end
                ST_FLASH_ON: begin
                    if (timer_tc) begin
                        state <= ST_FLASH_OFF;
                    end
                end
                ST_FLASH_OFF: begin
                    if (timer_tc) begin
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state        <= ST_IDLE;
                            o_Busy       <= 1'b0;
                            o_Flash_Done <= 1'b1;
                        end else begin
                            state <= ST_FLASH_ON;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    o_Busy <= 1'b0;
                end
            endcase
        end
    end

    // Blanking only masks the output; the sequence timing is untouched.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Digit <= BLANK_DIGIT;
        end else if (i_Blank) begin
            o_Digit <= BLANK_DIGIT;
        end else begin
            case (state)
                ST_FLASH_ON:  o_Digit <= flash_value;
                ST_FLASH_OFF: o_Digit <= BLANK_DIGIT;
                default:      o_Digit <= i_Level;
            endcase
        end
    end

endmodule

// File: tb/tb_segment_display_sequencer.sv
// Bench for segment_display_sequencer: directed vector table, a blink-pattern
// trace, randomized traffic against a schedule-based model, and mid-run reset.
module tb_segment_display_sequencer;

    localparam int HP = 4;
    localparam int CW = 3;

    logic          i_Clk = 1'b0;
    logic          i_Rst_L = 1'b1;
    logic [3:0]    i_Level = 4'd3;
    logic          i_Flash_Req = 1'b0;
    logic [3:0]    i_Flash_Value = 4'd0;
    logic [CW-1:0] i_Flash_Count = '0;
    logic          i_Blank = 1'b0;
    logic [3:0]    o_Digit;
    logic          o_Busy;
    logic          o_Flash_Done;

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;

    always #5 i_Clk = ~i_Clk;

    segment_display_sequencer #(
        .HALF_PERIOD(HP),
        .CNT_W      (CW)
    ) dut (
        .i_Clk        (i_Clk),
        .i_Rst_L      (i_Rst_L),
        .i_Level      (i_Level),
        .i_Flash_Req  (i_Flash_Req),
        .i_Flash_Value(i_Flash_Value),
        .i_Flash_Count(i_Flash_Count),
        .i_Blank      (i_Blank),
        .o_Digit      (o_Digit),
        .o_Busy       (o_Busy),
        .o_Flash_Done (o_Flash_Done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    // Reference model: a sequence is a window [start, start+len) of edge indices;
    // outputs follow from the position inside that window.
    int         cyc = 0;
    bit         m_act = 1'b0;
    int         m_st = 0;
    int         m_len = 0;
    logic [3:0] m_val = 4'd0;
    logic [3:0] e_digit = 4'hF;
    logic       e_busy = 1'b0;
    logic       e_done = 1'b0;

    function automatic bit in_seq(bit a, int s, int l, int n);
        return a && (n >= s) && (n < s + l);
    endfunction

    always @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cyc     <= 0;
            m_act   <= 1'b0;
            m_st    <= 0;
            m_len   <= 0;
            m_val   <= 4'd0;
            e_digit <= 4'hF;
            e_busy  <= 1'b0;
            e_done  <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (i_Blank)
                e_digit <= 4'hF;
            else if (in_seq(m_act, m_st, m_len, cyc))
                e_digit <= (((cyc - m_st) / HP) % 2 == 0) ? m_val : 4'hF;
            else
                e_digit <= i_Level;
            if (i_Flash_Req && (i_Flash_Count != 0) && !e_busy && !e_done) begin
                m_act  <= 1'b1;
                m_st   <= cyc + 1;
                m_len  <= int'(i_Flash_Count) * 2 * HP;
                m_val  <= i_Flash_Value;
                e_busy <= 1'b1;
                e_done <= 1'b0;
            end else begin
                e_busy <= in_seq(m_act, m_st, m_len, cyc + 1);
                e_done <= m_act && (cyc + 1 == m_st + m_len);
            end
        end
    end

    always @(negedge i_Clk) begin
        if (mon_en) begin
            chk("mon_digit", o_Digit, e_digit);
            chk("mon_busy", o_Busy, e_busy);
            chk("mon_done", o_Flash_Done, e_done);
        end
    end

    typedef struct {
        logic [3:0] val;
        int         cnt;
        logic [3:0] lvl;
        logic [3:0] mid;
        int         bo;
        int         bl;
        int         r2;
        bit         rdone;
        int         exp_len;
        int         exp_val;
        logic [3:0] exp_after;
    } vec_t;

    vec_t tbl[5];

    task automatic send_req(input logic [3:0] v, input int c);
        @(negedge i_Clk);
        i_Flash_Value = v;
        i_Flash_Count = CW'(c);
        i_Flash_Req   = 1'b1;
        @(negedge i_Clk);
        i_Flash_Req   = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, nv, done_i;
        tbl[0] = '{4'd7,  2, 4'd3, 4'd3, -1, 0, -1, 1'b0, 16,  8, 4'd3};
        tbl[1] = '{4'd9,  1, 4'd2, 4'd2, -1, 0, -1, 1'b1,  8,  4, 4'd2};
        tbl[2] = '{4'd6,  3, 4'd3, 4'd3,  1, 3, 10, 1'b0, 24,  9, 4'd3};
        tbl[3] = '{4'd8,  2, 4'd3, 4'd4, -1, 0, -1, 1'b0, 16,  8, 4'd4};
        tbl[4] = '{4'hC,  7, 4'd1, 4'd1, -1, 0, -1, 1'b1, 56, 28, 4'd1};

        // Reset with level 3
        #1 i_Rst_L = 1'b0;
        #1 mon_en = 1'b1;
        repeat (2) @(negedge i_Clk);
        chk("rst_digit", o_Digit, 4'hF);
        chk("rst_busy", o_Busy, 1'b0);
        chk("rst_done", o_Flash_Done, 1'b0);
        i_Rst_L = 1'b1;
        @(negedge i_Clk);
        chk("rel_digit", o_Digit, 4'd3);
        chk("rel_busy", o_Busy, 1'b0);

        // Exact blink trace: 7 x4, F x4, 7 x4, F x4, then level
        send_req(4'd7, 2);
        for (int i = 0; i < 16; i++) begin
            @(negedge i_Clk);
            chk("trace_digit", o_Digit, (((i / 4) % 2) == 0) ? 4'd7 : 4'hF);
            chk("trace_busy", o_Busy, (i < 15) ? 1'b1 : 1'b0);
            chk("trace_done", o_Flash_Done, (i == 15) ? 1'b1 : 1'b0);
        end
        @(negedge i_Clk);
        chk("trace_level", o_Digit, 4'd3);

        for (int t = 0; t < 5; t++) begin
            i_Level = tbl[t].lvl;
            repeat (2) @(negedge i_Clk);
            send_req(tbl[t].val, tbl[t].cnt);
            nb = 0; nv = 0; done_i = -1;
            for (int i = 0; i < 200; i++) begin
                if (o_Busy) nb++;
                if (o_Digit == tbl[t].val) nv++;
                if (o_Flash_Done) begin
                    done_i = i;
                    break;
                end
                i_Blank = (i >= tbl[t].bo) && (i < tbl[t].bo + tbl[t].bl);
                if (i == tbl[t].r2) begin
                    i_Flash_Value = 4'd5;
                    i_Flash_Count = CW'(1);
                    i_Flash_Req   = 1'b1;
                end else begin
                    i_Flash_Req = 1'b0;
                end
                if (i == 5) i_Level = tbl[t].mid;
                @(negedge i_Clk);
            end
            i_Blank = 1'b0;
            i_Flash_Req = 1'b0;
            chk("vec_done_cycle", done_i, tbl[t].exp_len);
            chk("vec_busy_cycles", nb, tbl[t].exp_len);
            chk("vec_value_cycles", nv, tbl[t].exp_val);
            if (tbl[t].rdone) begin
                i_Flash_Value = 4'd5;
                i_Flash_Count = CW'(1);
                i_Flash_Req   = 1'b1;
            end
            @(negedge i_Clk);
            i_Flash_Req = 1'b0;
            chk("vec_after_digit", o_Digit, tbl[t].exp_after);
            chk("vec_after_busy", o_Busy, 1'b0);
        end

        // Count of zero is ignored
        i_Level = 4'd3;
        send_req(4'd4, 0);
        repeat (10) begin
            chk("zero_busy", o_Busy, 1'b0);
            chk("zero_done", o_Flash_Done, 1'b0);
            @(negedge i_Clk);
        end

        // Blank while idle
        i_Blank = 1'b1;
        repeat (2) @(negedge i_Clk);
        chk("idle_blank", o_Digit, 4'hF);
        i_Blank = 1'b0;
        @(negedge i_Clk);
        chk("idle_unblank", o_Digit, 4'd3);

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 600; i++) begin
            @(negedge i_Clk);
            i_Flash_Req   = ($urandom_range(0, 9) == 0);
            i_Flash_Value = 4'($urandom_range(0, 15));
            i_Flash_Count = CW'($urandom_range(0, 7));
            i_Blank       = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 9) == 0) i_Level = 4'($urandom_range(0, 15));
        end
        i_Flash_Req = 1'b0;
        i_Blank = 1'b0;
        i_Level = 4'd3;
        for (int i = 0; i < 80 && o_Busy; i++) @(negedge i_Clk);
        chk("rand_settle_busy", o_Busy, 1'b0);
        repeat (2) @(negedge i_Clk);

        // Reset in the middle of a FLASH_ON phase
        send_req(4'd7, 3);
        repeat (2) @(negedge i_Clk);
        chk("pre_rst_digit", o_Digit, 4'd7);
        #2 i_Rst_L = 1'b0;
        #1;
        chk("abort_digit", o_Digit, 4'hF);
        chk("abort_busy", o_Busy, 1'b0);
        chk("abort_done", o_Flash_Done, 1'b0);
        repeat (3) @(negedge i_Clk);
        i_Rst_L = 1'b1;
        @(negedge i_Clk);
        chk("post_rst_digit", o_Digit, 4'd3);
        chk("post_rst_busy", o_Busy, 1'b0);
        repeat (30) @(negedge i_Clk);
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
